icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped instruction cache with a word-serial refill engine. It sits directly upstream of the fetch stage. Fetch presents a line address and receives a whole instruction line, 32 words of 32 bits. On a miss the block fills the line from instruction memory, one word per memory handshake, and holds `miss` high until the line is installed.

## Interface
- `WORD_SIZE`, 32, instruction/memory word width in bits
- `LINE_WORDS`, 32, words per line; the line is 128 bytes, matching fetch's `pc+128` stride
- `INDEX_BITS`, 3, line index width (8 lines)
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in`  in  WORD_SIZE  byte address from fetch; bits [6:0] are ignored
- `rd`  in  1  lookup strobe from fetch
- `flush`  in  1  invalidate-all request
- `out`  out  LINE_WORDS*WORD_SIZE  indexed line; word k occupies bits [1023-32k -: 32], so word 0 is in the MSBs
- `miss`  out  1  line not available; `out` is invalid while this is high
- `mem_req`  out  1  word read request
- `mem_addr`  out  WORD_SIZE  byte address of the requested word
- `mem_rdata`  in  WORD_SIZE  returned word
- `mem_rvalid`  in  1  `mem_rdata` valid; completes the current request

## Operation
- Address split:
  - offset = [6:0]
  - index = [6+INDEX_BITS:7]
  - tag = [WORD_SIZE-1:7+INDEX_BITS]
- Per line the block stores a valid bit, a tag and 1024 data bits. The data array has no reset.
- hit = valid[index] & (tag_store[index] == tag). Evaluated combinationally from `in`.
- `out` = data[index] when valid[index], else all zeros. `out` does not depend on the tag.
- FSM states:
  - IDLE:
    - `rd` & !hit: capture {tag,index} into the fill base, clear word counter cnt, go to FILL.
    - `rd` & hit: stay in IDLE.
  - FILL:
    - `mem_req`=1, `mem_addr` = base + (cnt<<2).
    - On `mem_rvalid`: write `mem_rdata` into word cnt of a line buffer, then cnt++.
    - On the `mem_rvalid` for cnt=LINE_WORDS-1: write the buffer to data[index], set valid, write the tag, return to IDLE.
- `miss` = (state != IDLE) | (`rd` & !hit).
- `in` may change during FILL. The fill always completes for the captured address. The next `rd` re-evaluates hit.
- `flush`:
  - In IDLE: clears all valid bits at the edge. If `rd` is high in the same cycle, the lookup is treated as a miss.
  - During FILL: latched as pending. Applied on the same edge the fill completes, so the freshly filled line is also left invalid.
- Conflict: a fill overwrites the line's tag and data unconditionally. There is no write-back.
- Reset, including reset asserted mid-fill:
  - state=IDLE, all valid=0, pending flush=0, cnt=0
  - `mem_req`=0, `mem_addr`=0, `miss`=0 (with `rd` low), `out`=0
  - The in-flight fill is abandoned; a late `mem_rvalid` in IDLE is ignored.

## Timing
- Hit: zero-cycle latency. With `rd` high, `miss`=0 and `out` is valid in the same cycle.
- Miss:
  - `rd` sampled at edge T.
  - `mem_req` rises after T with the address of word 0.
  - With `mem_rvalid` returned every cycle, the last word is captured at edge T+32.
  - `miss` falls in the cycle after T+32, provided `in` still addresses that line: 33-cycle minimum miss penalty.
- `mem_req` stays high for the entire fill. At most one request is outstanding. `mem_addr` advances in the cycle after each `mem_rvalid`.
- Memory stalls (`mem_rvalid` low) extend FILL indefinitely. There is no timeout.

## Configuration
- Macro: `ICACHE_STATS_EN`.
- Defined:
  - Adds outputs `hit_count` and `miss_count`, each 32 bits.
  - `hit_count` increments on each IDLE cycle with `rd` & hit.
  - `miss_count` increments on each IDLE→FILL transition.
  - Both saturate at 0xFFFFFFFF and reset to 0. `flush` does not clear them.
- Undefined: the ports and counters are absent. Miss and refill behaviour is identical either way.

## Test plan
- Cold miss:
  - Stimulus: reset, then `in`=0x00000000, `rd`=1; memory returns word k = 0xA000_0000+k with 1-cycle latency.
  - Required: `mem_addr` steps 0x00..0x7C; `miss` falls 33 cycles after `rd`; `out[1023:992]`=0xA0000000 and `out[31:0]`=0xA000001F.
- Hit after fill: `in`=0x00000040 with `rd` → `miss`=0 the same cycle, no `mem_req`, `out` unchanged.
- Conflict:
  - Stimulus: fill 0x000, then `rd` at 0x400 (same index 0, different tag).
  - Required: a refill issues `mem_addr` 0x400..0x47C; a later `rd` at 0x000 misses again.
- Flush:
  - Stimulus: after a fill, pulse `flush` in IDLE; separately, pulse `flush` during FILL word 10.
  - Required: the next `rd` misses in both cases; the mid-fill flush leaves the just-filled line invalid.
- Stalled memory and reset mid-fill:
  - Stimulus: hold `mem_rvalid` low 5 cycles per word, then assert `rst` at word 20.
  - Required: `mem_req` stays high through the stalls; after `rst`, `mem_req`=0, state IDLE, a stray `mem_rvalid` is ignored, and a re-`rd` restarts at word 0.
- `ICACHE_STATS_EN`:
  - Stimulus: 1 cold miss, 3 hits, 1 conflict miss.
  - Required: `hit_count`=3, `miss_count`=2; reset returns both to 0.

Source files
------------

// File: rtl/icache_ctrl_if.sv
// ----------------------------------------------------------------------------
// icache_ctrl_if
//   Bundles the fetch-side lookup signals and the instruction-memory refill
//   signals of icache_ctrl.
//
//   Fetch side : in (byte address), rd (lookup strobe), flush (invalidate all),
//                out (indexed line, word 0 in the MSBs), miss
//   Memory side: mem_req, mem_addr (byte address of requested word),
//                mem_rdata, mem_rvalid (completes the current request)
//
//   modport master : fetch stage + memory model (drives in/rd/flush/mem_rdata/
//                    mem_rvalid)
//   modport slave  : the cache controller
// ----------------------------------------------------------------------------
interface icache_ctrl_if #(
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 32
);
  logic [WORD_SIZE-1:0]            in;
  logic                            rd;
  logic                            flush;
  logic [LINE_WORDS*WORD_SIZE-1:0] out;
  logic                            miss;
  logic                            mem_req;
  logic [WORD_SIZE-1:0]            mem_addr;
  logic [WORD_SIZE-1:0]            mem_rdata;
  logic                            mem_rvalid;

  modport master (
    output in, rd, flush, mem_rdata, mem_rvalid,
    input  out, miss, mem_req, mem_addr
  );

  modport slave (
    input  in, rd, flush, mem_rdata, mem_rvalid,
    output out, miss, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// ----------------------------------------------------------------------------
// icache_ctrl
//   Direct-mapped instruction cache with a word-serial refill engine.
//   Fetch presents a line address and gets the whole line back combinationally
//   on a hit. On a miss the line is refilled one word per memory handshake into
//   a line buffer and installed when the last word arrives.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     bus        icache_ctrl_if.slave (fetch lookup + memory refill signals)
//     hit_count  (ICACHE_STATS_EN only) saturating count of IDLE hits
//     miss_count (ICACHE_STATS_EN only) saturating count of refills started
//
//   Optional feature: define ICACHE_STATS_EN to add the hit/miss counters.
//   Without it the counters and their ports are absent; cache behaviour is
//   the same either way.
// ----------------------------------------------------------------------------
module icache_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 32,
  parameter int INDEX_BITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  icache_ctrl_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int LINE_BITS  = LINE_WORDS * WORD_SIZE;
  localparam int WORD_BYTES = WORD_SIZE / 8;
  localparam int OFF_BITS   = $clog2(LINE_WORDS * WORD_BYTES);
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int TAG_BITS   = WORD_SIZE - OFF_BITS - INDEX_BITS;
  localparam int CNT_BITS   = $clog2(LINE_WORDS);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t                  r_state;
  logic [LINES-1:0]        r_valid;
  logic [TAG_BITS-1:0]     r_tag  [LINES];
  logic [LINE_BITS-1:0]    r_data [LINES];
  logic [LINE_BITS-1:0]    r_buf;
  logic [TAG_BITS-1:0]     r_base_tag;
  logic [INDEX_BITS-1:0]   r_base_idx;
  logic [CNT_BITS-1:0]     r_cnt;
  logic                    r_flush_pend;
  logic                    r_mem_req;
  logic [WORD_SIZE-1:0]    r_mem_addr;

  logic [INDEX_BITS-1:0]   w_index;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_hit;
  logic                    w_lookup_hit;
  logic                    w_start;
  logic                    w_last;
  logic                    w_word_in;
  logic [CNT_BITS-1:0]     w_slot;
  logic [LINE_BITS-1:0]    w_buf_next;
  logic                    w_unused_offset;

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  assign w_index = bus.in[OFF_BITS +: INDEX_BITS];
  assign w_tag   = bus.in[WORD_SIZE-1 -: TAG_BITS];

  // Byte offset within the line plays no part in a line lookup.
  assign w_unused_offset = ^bus.in[OFF_BITS-1:0];

  assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // A flush in the same cycle as a lookup wipes the line at this edge, so the
  // lookup must already be reported (and serviced) as a miss.
  assign w_lookup_hit = w_hit && !bus.flush;

  assign w_start = (r_state == IDLE) && bus.rd && !w_lookup_hit;

  assign bus.miss     = (r_state != IDLE) || (bus.rd && !w_lookup_hit);
  assign bus.out      = r_valid[w_index] ? r_data[w_index] : '0;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;

  // ---------------------------------------------------------------------------
  // Refill datapath
  // ---------------------------------------------------------------------------
  assign w_word_in = (r_state == FILL) && bus.mem_rvalid;
  assign w_last    = (r_cnt == CNT_BITS'(LINE_WORDS - 1));

  // Word k lives at the MSB end for k=0, so the slot counts down from the top.
  assign w_slot = CNT_BITS'(LINE_WORDS - 1) - r_cnt;

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[int'(w_slot) * WORD_SIZE +: WORD_SIZE] = bus.mem_rdata;
  end

  // Data, tag and buffer storage carry no reset; validity alone gates use.
  // The merged buffer is written on the last word so the final word does not
  // need an extra cycle to land in r_buf first.
  always_ff @(posedge clk) begin
    if (w_word_in) begin
      r_buf <= w_buf_next;
      if (w_last) begin
        r_data[r_base_idx] <= w_buf_next;
        r_tag[r_base_idx]  <= r_base_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_base_tag   <= '0;
      r_base_idx   <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.flush) begin
            r_valid <= '0;
          end
          if (w_start) begin
            r_base_tag   <= w_tag;
            r_base_idx   <= w_index;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b1;
            r_mem_addr   <= {w_tag, w_index, {OFF_BITS{1'b0}}};
            r_state      <= FILL;
          end
        end

        FILL: begin
          if (bus.flush) begin
            r_flush_pend <= 1'b1;
          end
          if (bus.mem_rvalid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              // A flush seen at any point of the fill (including this edge)
              // also discards the line being installed.
              if (r_flush_pend || bus.flush) begin
                r_valid <= '0;
              end else begin
                r_valid[r_base_idx] <= 1'b1;
              end
              r_flush_pend <= 1'b0;
              r_mem_req    <= 1'b0;
              r_mem_addr   <= '0;
              r_state      <= IDLE;
            end else begin
              r_mem_addr <= r_mem_addr + WORD_SIZE'(WORD_BYTES);
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters; flush leaves them untouched.
  // ---------------------------------------------------------------------------
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if ((r_state == IDLE) && bus.rd && w_lookup_hit && (r_hit_count != '1)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_start && (r_miss_count != '1)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
  localparam int WS = 32;
  localparam int LW = 32;
  localparam int IB = 3;
  localparam int NL = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  icache_ctrl_if #(.WORD_SIZE(WS), .LINE_WORDS(LW)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_ctrl #(.WORD_SIZE(WS), .LINE_WORDS(LW), .INDEX_BITS(IB)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: per-line valid/tag/word array, plus expected counters.
  // ---------------------------------------------------------------------------
  bit          m_valid [NL];
  logic [21:0] m_tag   [NL];
  logic [31:0] m_data  [NL][LW];
  int unsigned m_hits;
  int unsigned m_misses;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        exp_miss;
    logic [31:0] exp_w0;
    logic [31:0] exp_w31;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  function automatic int line_idx(input logic [31:0] a);
    return int'(a[9:7]);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[line_idx(a)] && (m_tag[line_idx(a)] == a[31:10]);
  endfunction

  function automatic logic [1023:0] exp_out(input logic [31:0] a);
    logic [1023:0] r;
    int idx;
    r = '0;
    idx = line_idx(a);
    if (m_valid[idx]) begin
      for (int k = 0; k < LW; k++) r[1023 - 32*k -: 32] = m_data[idx][k];
    end
    return r;
  endfunction

  task automatic model_clear_valid();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_valid();
    m_hits   = 0;
    m_misses = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    int first;
    n_checks++;
    if (act !== exp) begin
      n_err++;
      first = 0;
      for (int k = LW - 1; k >= 0; k--) begin
        if (act[1023 - 32*k -: 32] !== exp[1023 - 32*k -: 32]) first = k;
      end
      $display("FAIL %s word%0d act=%h exp=%h t=%0t", nm, first,
               act[1023 - 32*first -: 32], exp[1023 - 32*first -: 32], $time);
    end
  endtask

  task automatic chk_stats(input string nm);
`ifdef ICACHE_STATS_EN
    chk32({nm, "_hit_count"}, hit_count, m_hits);
    chk32({nm, "_miss_count"}, miss_count, m_misses);
`else
    chk32({nm, "_miss_idle"}, 32'(bus.miss), 32'(bus.rd));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lookup expected to hit: zero-latency line, no refill started.
  task automatic lookup_hit(input logic [31:0] a);
    bus.in = a; bus.rd = 1'b1; bus.flush = 1'b0;
    #1;
    chk32("hit_miss", 32'(bus.miss), 32'd0);
    chk_line("hit_out", bus.out, exp_out(a));
    step();
    m_hits++;
    bus.rd = 1'b0;
    chk32("hit_no_req", 32'(bus.mem_req), 32'd0);
  endtask

  // Lookup expected to miss, followed by a full (or reset-aborted) refill.
  task automatic miss_fill(input logic [31:0] a, input int stall, input int flush_at,
                           input int rst_at, input bit flush_with_rd);
    logic [31:0] base;
    int idx;
    bit pend;
    base = {a[31:7], 7'b0};
    idx  = line_idx(a);
    pend = 1'b0;
    bus.in = a; bus.rd = 1'b1; bus.flush = flush_with_rd; bus.mem_rvalid = 1'b0;
    #1;
    chk32("lookup_miss", 32'(bus.miss), 32'd1);
    step();
    if (flush_with_rd) model_clear_valid();
    m_misses++;
    bus.rd = 1'b0; bus.flush = 1'b0;
    #1;
    chk32("fill_miss_state", 32'(bus.miss), 32'd1);
    for (int k = 0; k < LW; k++) begin
      for (int s = 0; s < stall; s++) begin
        chk32("stall_req", 32'(bus.mem_req), 32'd1);
        chk32("stall_addr", bus.mem_addr, base + 32'(4*k));
        step();
      end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk32("rst_req", 32'(bus.mem_req), 32'd0);
        chk32("rst_addr", bus.mem_addr, 32'd0);
        chk32("rst_miss", 32'(bus.miss), 32'd0);
        chk_line("rst_out", bus.out, '0);
        chk_stats("rst_mid");
        #2;
        rst = 1'b0;
        return;
      end
      chk32("fill_req", 32'(bus.mem_req), 32'd1);
      chk32("fill_addr", bus.mem_addr, base + 32'(4*k));
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_word(base + 32'(4*k));
      bus.flush      = (k == flush_at);
      if (k == flush_at) pend = 1'b1;
      step();
      bus.mem_rvalid = 1'b0;
      bus.flush      = 1'b0;
    end
    for (int k = 0; k < LW; k++) m_data[idx][k] = mem_word(base + 32'(4*k));
    m_tag[idx] = a[31:10];
    if (pend) model_clear_valid();
    else m_valid[idx] = 1'b1;
    chk32("done_req", 32'(bus.mem_req), 32'd0);
    chk32("done_addr", bus.mem_addr, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    int op;

    tbl[0] = '{32'h0000_0000, 1'b1, 1'b0, 32'hA000_0000, 32'hA000_001F};
    tbl[1] = '{32'h0000_0040, 1'b1, 1'b0, 32'hA000_0000, 32'hA000_001F};
    tbl[2] = '{32'h0000_007F, 1'b1, 1'b0, 32'hA000_0000, 32'hA000_001F};
    tbl[3] = '{32'h0000_0180, 1'b1, 1'b0, 32'hA000_0060, 32'hA000_007F};
    tbl[4] = '{32'h0000_0400, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_001F};
    tbl[5] = '{32'h0000_0080, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[6] = '{32'h0000_0080, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[7] = '{32'h0000_0400, 1'b0, 1'b0, 32'hA000_0000, 32'hA000_001F};

    rst = 1'b1;
    bus.in = '0; bus.rd = 1'b0; bus.flush = 1'b0;
    bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk32("reset_req", 32'(bus.mem_req), 32'd0);
    chk32("reset_addr", bus.mem_addr, 32'd0);
    chk32("reset_miss", 32'(bus.miss), 32'd0);
    chk_line("reset_out", bus.out, '0);
    chk_stats("reset");
    rst = 1'b0;
    step();

    // Cold miss at 0x0 with 1-cycle memory latency.
    miss_fill(32'h0, 0, -1, -1, 1'b0);
    bus.in = 32'h0; bus.rd = 1'b1;
    #1;
    chk32("cold_miss_falls", 32'(bus.miss), 32'd0);
    chk32("cold_w0", bus.out[1023:992], 32'hA000_0000);
    chk32("cold_w31", bus.out[31:0], 32'hA000_001F);
    bus.rd = 1'b0;
    step();

    lookup_hit(32'h0000_0040);
    lookup_hit(32'h0000_007F);

    miss_fill(32'h0000_0180, 1, -1, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      bus.in = tbl[i].addr; bus.rd = tbl[i].rd;
      #1;
      chk32("tbl_miss", 32'(bus.miss), 32'(tbl[i].exp_miss));
      chk32("tbl_w0", bus.out[1023:992], tbl[i].exp_w0);
      chk32("tbl_w31", bus.out[31:0], tbl[i].exp_w31);
      bus.rd = 1'b0;
      step();
    end

    // Conflict: same index 0, different tag, then original line misses again.
    miss_fill(32'h0000_0400, 0, -1, -1, 1'b0);
    bus.in = 32'h0; bus.rd = 1'b1;
    #1;
    chk32("conflict_remiss", 32'(bus.miss), 32'd1);
    bus.rd = 1'b0;
    step();

    // Flush in IDLE.
    lookup_hit(32'h0000_0400);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    model_clear_valid();
    bus.in = 32'h0000_0400; bus.rd = 1'b1;
    #1;
    chk32("flush_idle_miss", 32'(bus.miss), 32'd1);
    chk_line("flush_idle_out", bus.out, '0);
    bus.rd = 1'b0;
    step();

    // Flush coincident with a lookup that would otherwise hit.
    miss_fill(32'h0000_0400, 0, -1, -1, 1'b0);
    miss_fill(32'h0000_0400, 0, -1, -1, 1'b1);
    lookup_hit(32'h0000_0400);

    // Flush during word 10 leaves the freshly filled line invalid.
    miss_fill(32'h0000_0180, 0, 10, -1, 1'b0);
    bus.in = 32'h0000_0180; bus.rd = 1'b1;
    #1;
    chk32("midflush_miss", 32'(bus.miss), 32'd1);
    chk_line("midflush_out", bus.out, '0);
    bus.rd = 1'b0;
    step();

    // Stalled memory, reset at word 20, stray rvalid, then restart.
    miss_fill(32'h0000_0800, 5, -1, 20, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_rvalid = 1'b0;
    chk32("stray_rvalid_req", 32'(bus.mem_req), 32'd0);
    chk32("stray_rvalid_miss", 32'(bus.miss), 32'd0);
    chk_line("stray_rvalid_out", bus.out, '0);
    miss_fill(32'h0000_0800, 0, -1, -1, 1'b0);
    lookup_hit(32'h0000_0800);
    chk_stats("directed");

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 7)
          | 32'($urandom_range(0, 127));
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        model_clear_valid();
      end else if (op == 1) begin
        bus.in = a; bus.rd = 1'b0;
        #1;
        chk32("rand_idle_miss", 32'(bus.miss), 32'd0);
        chk_line("rand_idle_out", bus.out, exp_out(a));
        step();
      end else if (m_hit(a) && ($urandom_range(0, 5) != 0)) begin
        lookup_hit(a);
      end else begin
        miss_fill(a, int'($urandom_range(0, 2)),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : -1,
                  -1, m_hit(a));
        bus.in = a; bus.rd = 1'b1;
        #1;
        chk32("rand_after_fill_miss", 32'(bus.miss), 32'(!m_hit(a)));
        chk_line("rand_after_fill_out", bus.out, exp_out(a));
        bus.rd = 1'b0;
        step();
      end
    end
    chk_stats("random");

    rst = 1'b1;
    #1;
    model_reset();
    chk_stats("final_reset");
    chk32("final_reset_req", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  // Absolute time guard so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
